fetch_sequencer: RTL and testbench

Instruction-fetch controller sitting between the program counter logic and the word-addressed instruction memory. It drives the 64-bit read address, captures each returned 32-bit instruction with its PC into a small prefetch FIFO, and hands instructions to decode over a valid/ready handshake. It also handles branch redirects (flush and reload), start/halt sequencing, and back-pressure from decode.

---
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives imem_addr, buffers returned words
// with their PCs in a prefetch FIFO and hands them to decode.
module fetch_sequencer #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   fetch_pc;
    logic [31:0]   instr_mem [DEPTH];
    logic [63:0]   pc_mem    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   last_instr;
    logic [63:0]   last_pc;
    logic          push;
    logic          pop;

    // A redirect freezes the state; halt_req beats a simultaneous start.
    always_comb begin
        state_nxt = state;
        if (!redirect_valid) begin
            unique case (state)
                IDLE:    if (start && !halt_req) state_nxt = FETCH;
                FETCH:   if (halt_req) state_nxt = HALTED;
                HALTED:  if (start && !halt_req) state_nxt = FETCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = (state == FETCH) & ~redirect_valid & ~halt_req
                     & ((count < FULL) | pop);

    assign imem_addr = fetch_pc;
    assign halted    = (state == HALTED);

    // Empty FIFO shows the last head seen, never imem_data.
    assign out_instr = out_valid ? instr_mem[rd_ptr] : last_instr;
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : last_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else begin
            state <= state_nxt;
            if (out_valid) begin
                last_instr <= instr_mem[rd_ptr];
                last_pc    <= pc_mem[rd_ptr];
            end
            if (redirect_valid) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= {redirect_target[63:2], 2'b00};
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + AW'(1);
                    fetch_pc <= fetch_pc + 64'd4;
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop) count <= count + (AW+1)'(1);
                else if (pop && !push) count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected PCs are queued when
// stimulus is driven and checked on every accepted transfer.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;

    int          vectors = 0;
    int          errors  = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h8b1f03e5;
            64'h4:   return 32'hf84000a4;
            64'h8:   return 32'h8b040086;
            64'hC:   return 32'hf80010a6;
            default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    always #5 clk = ~clk;

    fetch_sequencer #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .halt_req(halt_req),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .halted(halted)
    );

    // Mid-cycle: a valid&ready seen here completes at the next edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer: got pc=%h, none expected", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_pc !== mon_e || out_instr !== mem_word(mon_e)) begin
                    errors++;
                    $display("FAIL xfer: got pc=%h instr=%h, want pc=%h instr=%h",
                             out_pc, out_instr, mon_e, mem_word(mon_e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        start = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        out_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && out_valid; i++) tick();
    endtask

    task automatic test_reset();
        reset_dut();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        vectors++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", out_instr); end
        vectors++; if (out_pc !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", out_pc); end
        vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
        vectors++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0 || imem_addr !== 64'h0) begin errors++; $display("FAIL idle_nofetch: got v=%b a=%h want v=0 a=0", out_valid, imem_addr); end
    endtask

    task automatic test_stream();
        reset_dut();
        out_ready = 1'b1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h8);
        exp_q.push_back(64'hC);
        pulse_start();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL start_lat0: got %b want 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin errors++; $display("FAIL start_lat1: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
        tick();
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL stream_halt: got %b want 1", halted); end
        vectors++; if (imem_addr !== 64'h10) begin errors++; $display("FAIL stream_addr: got %h want 10", imem_addr); end
        wait_drain();
        vectors++; if (exp_q.size() != 0 || out_valid) begin errors++; $display("FAIL stream_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int n;
        reset_dut();
        pulse_start();
        repeat (8) tick();
        vectors++; if (imem_addr !== 64'h10) begin errors++; $display("FAIL bp_stall: got %h want 10", imem_addr); end
        vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
        for (int i = 0; i < 5; i++) exp_q.push_back(64'(4 * i));
        out_ready = 1'b1;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n = 0;
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        vectors++; if (n != 3) begin errors++; $display("FAIL bp_bubble: got %0d cycles want 3", n); end
        vectors++; if (imem_addr !== 64'h14) begin errors++; $display("FAIL bp_addr: got %h want 14", imem_addr); end
        vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        reset_dut();
        pulse_start();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_target = 64'h0B;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0 || imem_addr !== 64'h8) begin errors++; $display("FAIL redir_flush: got v=%b a=%h want v=0 a=8", out_valid, imem_addr); end
        vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL redir_state: got %b want 0", halted); end
        exp_q.push_back(64'h8);
        out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h8 || out_instr !== 32'h8b040086) begin errors++; $display("FAIL redir_head: got v=%b pc=%h i=%h want v=1 pc=8 i=8b040086", out_valid, out_pc, out_instr); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        wait_drain();
        vectors++; if (exp_q.size() != 0 || out_valid) begin errors++; $display("FAIL redir_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_redirect_pop();
        reset_dut();
        out_ready = 1'b1;
        exp_q.push_back(64'h0);
        pulse_start();
        tick();
        redirect_valid = 1'b1;
        redirect_target = 64'h100;
        exp_q.push_back(64'h100);
        tick();
        redirect_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0 || imem_addr !== 64'h100) begin errors++; $display("FAIL rpop_flush: got v=%b a=%h want v=0 a=100", out_valid, imem_addr); end
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        vectors++; if (exp_q.size() != 0 || out_valid) begin errors++; $display("FAIL rpop_left: got %0d want 0", exp_q.size()); end
        vectors++; if (out_pc !== 64'h100) begin errors++; $display("FAIL rpop_hold: got %h want 100", out_pc); end
    endtask

    task automatic test_halt_resume();
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(64'(4 * i));
        pulse_start();
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        vectors++; if (halted !== 1'b1 || imem_addr !== 64'hC) begin errors++; $display("FAIL hr_halt: got h=%b a=%h want h=1 a=c", halted, imem_addr); end
        repeat (3) tick();
        vectors++; if (out_valid !== 1'b0 || imem_addr !== 64'hC) begin errors++; $display("FAIL hr_idle: got v=%b a=%h want v=0 a=c", out_valid, imem_addr); end
        pulse_start();
        vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL hr_resume: got %b want 0", halted); end
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        wait_drain();
        vectors++; if (exp_q.size() != 0 || imem_addr !== 64'h14) begin errors++; $display("FAIL hr_left: got n=%0d a=%h want n=0 a=14", exp_q.size(), imem_addr); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        pulse_start();
        repeat (6) tick();
        vectors++; if (out_valid !== 1'b1 || out_instr !== 32'h8b1f03e5) begin errors++; $display("FAIL rm_full: got v=%b i=%h want v=1 i=8b1f03e5", out_valid, out_instr); end
        redirect_valid = 1'b1;
        redirect_target = 64'h40;
        start = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        redirect_valid = 1'b0;
        start = 1'b0;
        vectors++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 64'h0) begin errors++; $display("FAIL rm_out: got v=%b i=%h pc=%h want all 0", out_valid, out_instr, out_pc); end
        vectors++; if (imem_addr !== 64'h0 || halted !== 1'b0) begin errors++; $display("FAIL rm_addr: got a=%h h=%b want a=0 h=0", imem_addr, halted); end
        repeat (3) tick();
        vectors++; if (out_valid !== 1'b0 || imem_addr !== 64'h0) begin errors++; $display("FAIL rm_idle: got v=%b a=%h want v=0 a=0", out_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        reset_dut();
        pulse_start();
        redirect_valid = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_q.push_back(64'h0);
        vectors++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffffffffffc", imem_addr); end
        out_ready = 1'b1;
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        wait_drain();
        vectors++; if (exp_q.size() != 0 || imem_addr !== 64'h4) begin errors++; $display("FAIL wrap_left: got n=%0d a=%h want n=0 a=4", exp_q.size(), imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_halt_resume();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
